// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control FSM sequencing one shared req/ready memory port.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP and raise a sticky illegal flag.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ir,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic [2:0]       imm_sel,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             rf_we,
    output logic [1:0]       wd_sel,
    output logic [CNT_W-1:0] instret
`ifdef ILLEGAL_TRAP_EN
   ,output logic             illegal
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC, WB_ALU, ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP, TRAP
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       run;
    logic       retire;
    logic [6:0] opcode;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign unused_ir = ^{ir[31:13], ir[11:7]};

    // run holds FETCH idle for one cycle after reset so mem_req rises only once reset is gone
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            run     <= 1'b0;
            instret <= '0;
        end else begin
            state <= next_state;
            run   <= 1'b1;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal <= 1'b0;
        end else if (next_state == TRAP) begin
            illegal <= 1'b1;
        end
    end
`endif

    always_comb begin
        imm_sel = 3'd0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_sel = 3'd0;
            OP_STORE:                 imm_sel = 3'd1;
            OP_BRANCH:                imm_sel = 3'd2;
            OP_LUI, OP_AUIPC:         imm_sel = 3'd3;
            OP_JAL:                   imm_sel = 3'd4;
            default:                  imm_sel = 3'd0;
        endcase
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 2'd0;
        rf_we      = 1'b0;
        wd_sel     = 2'd0;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                if (run) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        pc_we      = 1'b1;
                        next_state = DECODE;
                    end
                end
            end
            DECODE: begin
                case (opcode)
                    OP_REG, OP_IMM, OP_LUI, OP_AUIPC: next_state = EXEC;
                    OP_LOAD, OP_STORE:                next_state = ADDR;
                    OP_BRANCH:                        next_state = BRANCH;
                    OP_JAL:                           next_state = JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:                          next_state = TRAP;
`else
                    default:                          next_state = FETCH;
`endif
                endcase
            end
            EXEC: begin
                alu_src_b  = (opcode == OP_IMM) || (opcode == OP_LUI) || (opcode == OP_AUIPC);
                alu_op     = (opcode == OP_LUI) ? 2'd3 : 2'd2;
                next_state = WB_ALU;
            end
            WB_ALU: begin
                rf_we      = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            ADDR: begin
                alu_src_b  = 1'b1;
                next_state = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = WB_MEM;
                end
            end
            MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            WB_MEM: begin
                rf_we      = 1'b1;
                wd_sel     = 2'd1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            // bit 12 of funct3 separates beq (0) from bne (1)
            BRANCH: begin
                alu_op     = 2'd1;
                pc_we      = alu_zero ^ ir[12];
                pc_src     = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                rf_we      = 1'b1;
                wd_sel     = 2'd2;
                pc_we      = 1'b1;
                pc_src     = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: begin
                next_state = TRAP;
            end
`endif
            default: begin
                next_state = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl walking addi, lw, beq/bne, jal, sw and an illegal opcode.
// ctrl packs {mem_req, iord, mem_we, ir_we, pc_we, pc_src, rf_we, alu_src_b}.
module tb_mc_ctrl;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0040A103;
    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] BNE  = 32'h00001463;
    localparam logic [31:0] JAL  = 32'h008000EF;
    localparam logic [31:0] SW   = 32'h0020A023;
    localparam logic [31:0] BAD  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = 32'd0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_b, rf_we;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_op, wd_sel;
    logic [31:0] instret;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    logic [7:0]  ctrl;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign ctrl = {mem_req, iord, mem_we, ir_we, pc_we, pc_src, rf_we, alu_src_b};

    mc_ctrl #(.CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .alu_zero  (alu_zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .imm_sel   (imm_sel),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .rf_we     (rf_we),
        .wd_sel    (wd_sel),
        .instret   (instret)
`ifdef ILLEGAL_TRAP_EN
       ,.illegal   (illegal)
`endif
    );

    // inputs change on the falling edge; outputs are sampled 1 time unit later
    task automatic applyStimulus(input logic rst_v, input logic [31:0] ir_v,
                                 input logic zero_v, input logic ready_v);
        @(negedge clk);
        reset     = rst_v;
        ir        = ir_v;
        alu_zero  = zero_v;
        mem_ready = ready_v;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic [7:0] exp);
        checkOutput(tag, 32'(ctrl), 32'(exp));
    endtask

    initial begin
        $display("[TB] start");
        // reset
        applyStimulus(1'b1, 32'd0, 1'b0, 1'b0);
        checkCtrl("reset_ctrl", 8'b0000_0000);
        checkOutput("reset_instret", instret, 32'd0);
        applyStimulus(1'b0, ADDI, 1'b0, 1'b1);
        checkCtrl("post_reset_idle", 8'b0000_0000);

        // addi: F, D, EX, WB
        applyStimulus(1'b0, ADDI, 1'b0, 1'b1);
        checkCtrl("addi_fetch", 8'b1001_1000);
        checkOutput("addi_imm_sel", 32'(imm_sel), 32'd0);
        applyStimulus(1'b0, ADDI, 1'b0, 1'b1);
        checkCtrl("addi_decode", 8'b0000_0000);
        applyStimulus(1'b0, ADDI, 1'b0, 1'b1);
        checkCtrl("addi_exec", 8'b0000_0001);
        checkOutput("addi_alu_op", 32'(alu_op), 32'd2);
        applyStimulus(1'b0, ADDI, 1'b0, 1'b1);
        checkCtrl("addi_wb", 8'b0000_0010);
        checkOutput("addi_wd_sel", 32'(wd_sel), 32'd0);
        checkOutput("addi_instret_before", instret, 32'd0);

        // lw with three wait cycles in MEM_RD
        applyStimulus(1'b0, LW, 1'b0, 1'b1);
        checkOutput("addi_instret_after", instret, 32'd1);
        checkCtrl("lw_fetch", 8'b1001_1000);
        applyStimulus(1'b0, LW, 1'b0, 1'b1);
        checkCtrl("lw_decode", 8'b0000_0000);
        applyStimulus(1'b0, LW, 1'b0, 1'b1);
        checkCtrl("lw_addr", 8'b0000_0001);
        checkOutput("lw_addr_alu_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, LW, 1'b0, 1'b0);
            checkCtrl("lw_mem_wait", 8'b1100_0000);
        end
        applyStimulus(1'b0, LW, 1'b0, 1'b1);
        checkCtrl("lw_mem_done", 8'b1100_0000);
        applyStimulus(1'b0, LW, 1'b0, 1'b1);
        checkCtrl("lw_wb", 8'b0000_0010);
        checkOutput("lw_wd_sel", 32'(wd_sel), 32'd1);

        // beq taken
        applyStimulus(1'b0, BEQ, 1'b1, 1'b1);
        checkOutput("lw_instret", instret, 32'd2);
        checkOutput("beq_imm_sel", 32'(imm_sel), 32'd2);
        applyStimulus(1'b0, BEQ, 1'b1, 1'b1);
        applyStimulus(1'b0, BEQ, 1'b1, 1'b1);
        checkCtrl("beq_taken", 8'b0000_1100);
        checkOutput("beq_alu_op", 32'(alu_op), 32'd1);

        // bne not taken
        applyStimulus(1'b0, BNE, 1'b1, 1'b1);
        checkOutput("beq_instret", instret, 32'd3);
        applyStimulus(1'b0, BNE, 1'b1, 1'b1);
        applyStimulus(1'b0, BNE, 1'b1, 1'b1);
        checkCtrl("bne_not_taken", 8'b0000_0100);

        // jal
        applyStimulus(1'b0, JAL, 1'b0, 1'b1);
        checkOutput("bne_instret", instret, 32'd4);
        checkOutput("jal_imm_sel", 32'(imm_sel), 32'd4);
        applyStimulus(1'b0, JAL, 1'b0, 1'b1);
        applyStimulus(1'b0, JAL, 1'b0, 1'b1);
        checkCtrl("jal_jump", 8'b0000_1110);
        checkOutput("jal_wd_sel", 32'(wd_sel), 32'd2);

        // sw interrupted by reset during the MEM_WR wait
        applyStimulus(1'b0, SW, 1'b0, 1'b1);
        checkOutput("jal_instret", instret, 32'd5);
        checkOutput("sw_imm_sel", 32'(imm_sel), 32'd1);
        applyStimulus(1'b0, SW, 1'b0, 1'b1);
        applyStimulus(1'b0, SW, 1'b0, 1'b1);
        checkCtrl("sw_addr", 8'b0000_0001);
        applyStimulus(1'b0, SW, 1'b0, 1'b0);
        checkCtrl("sw_mem_wait", 8'b1110_0000);
        applyStimulus(1'b1, SW, 1'b0, 1'b0);
        checkCtrl("sw_wait_reset_asserted", 8'b1110_0000);
        applyStimulus(1'b0, SW, 1'b0, 1'b1);
        checkCtrl("after_reset_ctrl", 8'b0000_0000);
        checkOutput("after_reset_instret", instret, 32'd0);
        applyStimulus(1'b0, SW, 1'b0, 1'b1);
        checkCtrl("after_reset_fetch", 8'b1001_1000);
        applyStimulus(1'b0, SW, 1'b0, 1'b1);
        applyStimulus(1'b0, SW, 1'b0, 1'b1);
        applyStimulus(1'b0, SW, 1'b0, 1'b1);
        checkCtrl("sw_mem_done", 8'b1110_0000);
        applyStimulus(1'b0, BAD, 1'b0, 1'b1);
        checkOutput("sw_instret", instret, 32'd1);

        // illegal opcode
        checkCtrl("bad_fetch", 8'b1001_1000);
        checkOutput("bad_imm_sel", 32'(imm_sel), 32'd0);
        applyStimulus(1'b0, BAD, 1'b0, 1'b1);
        checkCtrl("bad_decode", 8'b0000_0000);
`ifdef ILLEGAL_TRAP_EN
        checkOutput("bad_illegal_before", 32'(illegal), 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, BAD, 1'b0, 1'b1);
            checkCtrl("trap_ctrl", 8'b0000_0000);
            checkOutput("trap_illegal", 32'(illegal), 32'd1);
        end
        applyStimulus(1'b1, BAD, 1'b0, 1'b1);
        applyStimulus(1'b0, ADDI, 1'b0, 1'b1);
        checkOutput("trap_reset_illegal", 32'(illegal), 32'd0);
        applyStimulus(1'b0, ADDI, 1'b0, 1'b1);
        checkCtrl("trap_reset_fetch", 8'b1001_1000);
`else
        applyStimulus(1'b0, BAD, 1'b0, 1'b0);
        checkCtrl("bad_back_to_fetch", 8'b1000_0000);
        checkOutput("bad_instret", instret, 32'd1);
        applyStimulus(1'b0, BAD, 1'b0, 1'b0);
        checkOutput("bad_instret_hold", instret, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
